spi_tx_queue: RTL and testbench

SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

---
 rtl/spi_pkg.sv | 19 +
 rtl/sync_fifo_8bit.sv | 66 ++++++
 rtl/spi_tx_queue.sv | 110 +++++++++++
 tb/tb_spi_tx_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : shared defaults and FSM encodings for the SPI TX queue   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_pkg;

   localparam int DEPTH_DEFAULT   = 8;
   localparam int TIMEOUT_DEFAULT = 255;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE        = 2'd0;
   localparam logic [STATE_W-1:0] LOAD        = 2'd1;
   localparam logic [STATE_W-1:0] WAIT_ACCEPT = 2'd2;
   localparam logic [STATE_W-1:0] WAIT_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_8bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo_8bit : circular byte buffer with occupancy count         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_fifo_8bit
   import spi_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // Fullness is judged before any same-cycle pop, so a push into a full
   // queue is rejected even while the head is leaving.
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_tx_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_tx_queue : byte queue feeding an SPI sender with accept timeout|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_tx_queue
   import spi_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   CLR,
   input  logic                   PUSH,
   input  logic [7:0]             PUSH_DATA,
   input  logic                   CLEAR_ERR,
   input  logic                   SENDER_EMPTY,
   output logic                   FULL,
   output logic                   EMPTY,
   output logic [$clog2(DEPTH):0] LEVEL,
   output logic                   WRITE,
   output logic [7:0]             INCOMING_DATA,
   output logic                   BUSY,
   output logic                   OVERFLOW,
   output logic                   TIMEOUT_ERR
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [CW-1:0]      wait_cnt;
   logic [7:0]         head;
   logic               timeout_hit;

   sync_fifo_8bit #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .clr_n     (CLR),
      .push      (PUSH),
      .push_data (PUSH_DATA),
      .pop       (WRITE),
      .head      (head),
      .full      (FULL),
      .empty     (EMPTY),
      .level     (LEVEL)
   );

   assign WRITE = (state == LOAD);
   assign BUSY  = (state != IDLE);

   // Fires on the edge that would bring the counter to TIMEOUT.
   assign timeout_hit = (state == WAIT_ACCEPT) && SENDER_EMPTY
                        && (wait_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!EMPTY && SENDER_EMPTY) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = WAIT_ACCEPT;
         end
         WAIT_ACCEPT: begin
            if (!SENDER_EMPTY) begin
               state_nxt = WAIT_DONE;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         WAIT_DONE: begin
            if (SENDER_EMPTY) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         INCOMING_DATA <= 8'h00;
         OVERFLOW      <= 1'b0;
         TIMEOUT_ERR   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == LOAD) begin
            INCOMING_DATA <= head;
         end
         if (state == LOAD) begin
            wait_cnt <= '0;
         end else if (state == WAIT_ACCEPT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         // A set event in the same cycle as CLEAR_ERR keeps the flag high.
         OVERFLOW    <= (PUSH && FULL) || (OVERFLOW && !CLEAR_ERR);
         TIMEOUT_ERR <= timeout_hit || (TIMEOUT_ERR && !CLEAR_ERR);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_tx_queue : scoreboard bench for spi_tx_queue                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_spi_tx_queue;

   localparam int DEPTH = 8;
   localparam int TMO   = 24;

   logic       CLK;
   logic       CLR;
   logic       PUSH;
   logic [7:0] PUSH_DATA;
   logic       CLEAR_ERR;
   logic       SENDER_EMPTY;
   logic       FULL;
   logic       EMPTY;
   logic [3:0] LEVEL;
   logic       WRITE;
   logic [7:0] INCOMING_DATA;
   logic       BUSY;
   logic       OVERFLOW;
   logic       TIMEOUT_ERR;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_writes = 0;
   int         mlevel = 0;
   logic       exp_ovf = 1'b0;
   logic       model_on = 1'b0;
   logic       manual_se = 1'b1;
   logic [7:0] sb [$];

   spi_tx_queue #(
      .DEPTH         (DEPTH),
      .TIMEOUT       (TMO)
   ) dut (
      .CLK           (CLK),
      .CLR           (CLR),
      .PUSH          (PUSH),
      .PUSH_DATA     (PUSH_DATA),
      .CLEAR_ERR     (CLEAR_ERR),
      .SENDER_EMPTY  (SENDER_EMPTY),
      .FULL          (FULL),
      .EMPTY         (EMPTY),
      .LEVEL         (LEVEL),
      .WRITE         (WRITE),
      .INCOMING_DATA (INCOMING_DATA),
      .BUSY          (BUSY),
      .OVERFLOW      (OVERFLOW),
      .TIMEOUT_ERR   (TIMEOUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      PUSH      = 1'b1;
      PUSH_DATA = b;
      if (mlevel < DEPTH) begin
         sb.push_back(b);
         mlevel++;
      end else begin
         exp_ovf = 1'b1;
      end
      step();
      PUSH = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while ((sb.size() != 0 || BUSY) && n < max_cycles) begin
         step();
         n++;
      end
      check("drain_in_time", (n < max_cycles), 1'b1);
   endtask

   // Interface model: takes the byte the cycle after WRITE, stays busy 16 cycles.
   initial begin : iface_model
      logic saw_write;
      int   hold;
      saw_write    = 1'b0;
      hold         = 0;
      SENDER_EMPTY = 1'b1;
      forever begin
         @(posedge CLK);
         #2;
         if (!model_on) begin
            hold         = 0;
            saw_write    = 1'b0;
            SENDER_EMPTY = manual_se;
         end else begin
            if (hold > 0) begin
               hold--;
               SENDER_EMPTY = (hold == 0);
            end else if (saw_write) begin
               SENDER_EMPTY = 1'b0;
               hold         = 16;
            end else begin
               SENDER_EMPTY = 1'b1;
            end
            saw_write = WRITE;
         end
      end
   end

   initial begin : write_monitor
      logic [7:0] exp;
      forever begin
         @(negedge CLK);
         if (WRITE) begin
            n_writes++;
            if (sb.size() == 0) begin
               check("spurious_write", WRITE, 1'b0);
            end else begin
               exp = sb.pop_front();
               check("write_data", INCOMING_DATA, exp);
               mlevel--;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int w0;
      int n;
      CLR       = 1'b0;
      PUSH      = 1'b0;
      PUSH_DATA = 8'h00;
      CLEAR_ERR = 1'b0;
      repeat (3) step();
      check("rst_level", LEVEL, 0);
      check("rst_empty", EMPTY, 1);
      check("rst_full", FULL, 0);
      check("rst_write", WRITE, 0);
      check("rst_busy", BUSY, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_tmo", TIMEOUT_ERR, 0);
      check("rst_data", INCOMING_DATA, 8'h00);
      CLR = 1'b1;
      step();

      // single byte with latency check
      model_on = 1'b1;
      step();
      w0 = n_writes;
      push_byte(8'hA5);
      check("lat_empty_after_push", EMPTY, 0);
      check("lat_no_write_yet", WRITE, 0);
      step();
      check("lat_write_next", WRITE, 1);
      check("lat_data", INCOMING_DATA, 8'hA5);
      wait_drain(60);
      check("single_writes", n_writes - w0, 1);
      check("single_empty", EMPTY, 1);
      check("single_tmo", TIMEOUT_ERR, 0);

      // overfill while the sender is busy
      model_on  = 1'b0;
      manual_se = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
      check("fill_full", FULL, 1);
      check("fill_level", LEVEL, mlevel);
      check("fill_level8", LEVEL, 8);
      check("fill_ovf", OVERFLOW, exp_ovf);
      check("fill_idle", BUSY, 0);
      w0 = n_writes;
      model_on = 1'b1;
      wait_drain(500);
      check("fill_writes", n_writes - w0, 8);
      CLEAR_ERR = 1'b1;
      step();
      CLEAR_ERR = 1'b0;
      exp_ovf   = 1'b0;
      check("ovf_cleared", OVERFLOW, exp_ovf);

      // ordered stream through the interface model
      w0 = n_writes;
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      wait_drain(200);
      check("order_writes", n_writes - w0, 4);
      check("order_tmo", TIMEOUT_ERR, 0);

      // interface never accepts: timeout after exactly TMO cycles
      model_on  = 1'b0;
      manual_se = 1'b1;
      repeat (2) step();
      push_byte(8'hB1);
      push_byte(8'hB2);
      n = 0;
      while (!WRITE && n < 10) begin
         step();
         n++;
      end
      check("tmo_load_seen", WRITE, 1);
      step();
      repeat (TMO - 1) step();
      check("tmo_not_yet", TIMEOUT_ERR, 0);
      step();
      check("tmo_set", TIMEOUT_ERR, 1);
      check("tmo_idle", BUSY, 0);
      step();
      check("tmo_next_write", WRITE, 1);
      wait_drain(2 * TMO + 10);
      CLEAR_ERR = 1'b1;
      step();
      CLEAR_ERR = 1'b0;
      check("tmo_cleared", TIMEOUT_ERR, 0);

      // full queue: push and pop on the same edge
      manual_se = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
      check("pp_full", FULL, 1);
      manual_se = 1'b1;
      n = 0;
      while (!WRITE && n < 10) begin
         step();
         n++;
      end
      check("pp_load_seen", WRITE, 1);
      CLEAR_ERR = 1'b1;
      push_byte(8'h28);
      CLEAR_ERR = 1'b0;
      check("pp_level", LEVEL, 7);
      check("pp_ovf_set_wins", OVERFLOW, 1);
      check("pp_not_full", FULL, 0);

      // reset while in WAIT_DONE with three bytes queued
      CLR = 1'b0;
      step();
      CLR = 1'b1;
      sb.delete();
      mlevel  = 0;
      exp_ovf = 1'b0;
      model_on = 1'b1;
      repeat (20) step();
      for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
      check("mid_busy", BUSY, 1);
      check("mid_se_low", SENDER_EMPTY, 0);
      check("mid_level", LEVEL, 3);
      CLR = 1'b0;
      step();
      check("mid_rst_level", LEVEL, 0);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_empty", EMPTY, 1);
      check("mid_rst_write", WRITE, 0);
      check("mid_rst_data", INCOMING_DATA, 8'h00);
      CLR = 1'b1;
      sb.delete();
      mlevel = 0;
      w0 = n_writes;
      repeat (40) step();
      check("mid_no_write", n_writes - w0, 0);
      push_byte(8'h77);
      wait_drain(60);
      check("mid_new_write", n_writes - w0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
